// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse transmitter: sequencer state encoding and
// symbol word layout (level bit above the duration field).
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  localparam int DEFAULT_DURATION_BITS = 8;
  localparam int DEFAULT_SYM_WIDTH     = DEFAULT_DURATION_BITS + 1;

  function automatic int sym_width(input int duration_bits);
    return duration_bits + 1;
  endfunction

  function automatic int level_pos(input int duration_bits);
    return duration_bits;
  endfunction

endpackage

// File: rtl/pulse_symbol_mem.sv
// Symbol register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module pulse_symbol_mem
  import pulse_tx_pkg::*;
#(
  parameter int NUM_SYMBOLS = 8,
  parameter int SYM_WIDTH   = DEFAULT_SYM_WIDTH
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] waddr,
  input  logic [SYM_WIDTH-1:0]           wdata,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] raddr,
  output logic [SYM_WIDTH-1:0]           rdata
);

  logic [SYM_WIDTH-1:0] mem [NUM_SYMBOLS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A write in the same cycle as a read returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pulse_sequencer.sv
// Plays programmed level/duration symbols on pulse_out, timing each symbol by
// counting toggles of the shared prescaler timer output.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no sequence; timer held, pulse_out low
// LOAD    | one cycle: fetch symbol idx, set level and tick counter
// RUN     | timer free-running; each tim_out edge decrements the counter
module pulse_sequencer
  import pulse_tx_pkg::*;
#(
  parameter int PRESCALER_NUM_BITS = 4,
  parameter int NUM_SYMBOLS        = 8,
  parameter int DURATION_BITS      = 8,
  parameter int LOOP_BITS          = 8
) (
  input  logic                           clk,
  input  logic                           sys_rst,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] cfg_addr,
  input  logic [DURATION_BITS:0]         cfg_wdata,
  input  logic [PRESCALER_NUM_BITS-1:0]  cfg_prescaler,
  input  logic [$clog2(NUM_SYMBOLS)-1:0] cfg_last_idx,
  input  logic [LOOP_BITS-1:0]           cfg_loops,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           tim_out,
  output logic [PRESCALER_NUM_BITS-1:0]  tim_prescaler,
  output logic                           tim_hold,
  output logic                           pulse_out,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_SYMBOLS)-1:0] sym_idx
);

  localparam int IDX_BITS = $clog2(NUM_SYMBOLS);
  localparam int SYM_W    = sym_width(DURATION_BITS);
  localparam int LVL_POS  = level_pos(DURATION_BITS);

  seq_state_e                    state_q, state_d;
  logic [IDX_BITS-1:0]           idx_q, idx_d;
  logic [IDX_BITS-1:0]           last_q, last_d;
  logic [LOOP_BITS-1:0]          loops_q, loops_d;
  logic [DURATION_BITS-1:0]      dur_q, dur_d;
  logic [PRESCALER_NUM_BITS-1:0] presc_q, presc_d;
  logic                          pulse_q, pulse_d;
  logic                          hold_q, hold_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          tim_q;
  logic                          tick;
  logic [SYM_W-1:0]              rd_sym;

  pulse_symbol_mem #(
    .NUM_SYMBOLS (NUM_SYMBOLS),
    .SYM_WIDTH   (SYM_W)
  ) u_mem (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx_q),
    .rdata (rd_sym)
  );

  assign tick = tim_out ^ tim_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loops_d = loops_q;
    dur_d   = dur_q;
    presc_d = presc_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      pulse_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            presc_d = cfg_prescaler;
            last_d  = cfg_last_idx;
            loops_d = cfg_loops;
            idx_d   = '0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          pulse_d = rd_sym[LVL_POS];
          dur_d   = rd_sym[DURATION_BITS-1:0];
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            // A zero duration wraps to all-ones here, giving the full 2^N ticks.
            if (dur_q != DURATION_BITS'(1)) begin
              dur_d = dur_q - 1'b1;
            end else if (idx_q != last_q) begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_LOAD;
            end else if (loops_q != '0) begin
              loops_d = loops_q - 1'b1;
              idx_d   = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
              pulse_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
        end
      endcase
    end
    hold_d = (state_d != ST_RUN);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loops_q <= '0;
      dur_q   <= '0;
      presc_q <= '0;
      pulse_q <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loops_q <= loops_d;
      dur_q   <= dur_d;
      presc_q <= presc_d;
      pulse_q <= pulse_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tim_q   <= tim_out;
    end
  end

  assign tim_prescaler = presc_q;
  assign tim_hold      = hold_q;
  assign pulse_out     = pulse_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sym_idx       = idx_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: expected symbols are queued at start and
// matched against what a behavioural timer/monitor observes per symbol.
module tb_pulse_sequencer;

  localparam int PB   = 4;
  localparam int NS   = 8;
  localparam int DB   = 4;
  localparam int LB   = 8;
  localparam int AW   = 3;
  localparam int TPER = 4;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DB:0]   cfg_wdata = '0;
  logic [PB-1:0] cfg_prescaler = '0;
  logic [AW-1:0] cfg_last_idx = '0;
  logic [LB-1:0] cfg_loops = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tim_out = 1'b0;
  logic [PB-1:0] tim_prescaler;
  logic          tim_hold;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] sym_idx;

  typedef struct {
    logic lvl;
    int   ticks;
    int   idx;
    logic last;
  } exp_t;

  exp_t sb[$];
  logic tb_lvl [NS];
  int   tb_dur [NS];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_count = 0;
  logic idle_glitch = 1'b0;

  pulse_sequencer #(
    .PRESCALER_NUM_BITS (PB),
    .NUM_SYMBOLS        (NS),
    .DURATION_BITS      (DB),
    .LOOP_BITS          (LB)
  ) dut (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_prescaler (cfg_prescaler),
    .cfg_last_idx  (cfg_last_idx),
    .cfg_loops     (cfg_loops),
    .start         (start),
    .stop          (stop),
    .tim_out       (tim_out),
    .tim_prescaler (tim_prescaler),
    .tim_hold      (tim_hold),
    .pulse_out     (pulse_out),
    .busy          (busy),
    .done          (done),
    .sym_idx       (sym_idx)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural timer plus per-symbol monitor, evaluated on the falling edge.
  initial begin
    logic prev_hold;
    logic run_lvl;
    logic lvl_glitch;
    int   load_len;
    int   run_ticks;
    int   run_idx;
    int   tcnt;
    exp_t e;
    prev_hold = 1'b1; run_lvl = 1'b0; lvl_glitch = 1'b0;
    load_len = 0; run_ticks = 0; run_idx = 0; tcnt = 0;
    forever begin
      @(negedge clk);
      if (done) done_count++;
      if (!tim_hold) begin
        if (prev_hold) begin
          check_eq("load_len", load_len, 1);
          run_lvl    = pulse_out;
          run_idx    = int'(sym_idx);
          run_ticks  = 0;
          lvl_glitch = 1'b0;
        end else if (pulse_out !== run_lvl) begin
          lvl_glitch = 1'b1;
        end
        tcnt++;
        if (tcnt == TPER) begin
          tcnt = 0;
          tim_out = ~tim_out;
          run_ticks++;
        end
        load_len = 0;
      end else begin
        tcnt = 0;
        if (!prev_hold && (busy || done)) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check_eq("sym_level", run_lvl, e.lvl);
            check_eq("sym_ticks", run_ticks, e.ticks);
            check_eq("sym_idx", run_idx, e.idx);
            check_eq("level_stable", lvl_glitch, 0);
            check_eq("done_at_end", done, e.last);
            check_eq("busy_at_end", busy, !e.last);
            if (e.last) check_eq("pulse_idle", pulse_out, 0);
          end
        end
        if (busy) load_len++;
        else load_len = 0;
        if (idle_glitch) tim_out = ~tim_out;
      end
      prev_hold = tim_hold;
    end
  end

  task automatic write_hw(input int i, input logic l, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(i);
    cfg_wdata = {l, DB'(d)};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic write_sym(input int i, input logic l, input int d);
    tb_lvl[i] = l;
    tb_dur[i] = d;
    write_hw(i, l, d);
  endtask

  task automatic start_seq(input logic [PB-1:0] p, input int last, input int loops);
    for (int l = 0; l <= loops; l++) begin
      for (int i = 0; i <= last; i++) begin
        exp_t e;
        e.lvl   = tb_lvl[i];
        e.ticks = (tb_dur[i] == 0) ? (1 << DB) : tb_dur[i];
        e.idx   = i;
        e.last  = (l == loops) && (i == last);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    cfg_prescaler = p;
    cfg_last_idx  = AW'(last);
    cfg_loops     = LB'(loops);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_hold", tim_hold, 1);
    check_eq("start_presc", tim_prescaler, p);
    @(negedge clk);
    check_eq("run_hold", tim_hold, 0);
    check_eq("run_level", pulse_out, tb_lvl[0]);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check_eq("complete_in_budget", (c < budget), 1);
    check_eq("sb_drained", sb.size(), 0);
    if (c >= budget) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    int c;
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", pulse_out, 0);
    check_eq("rst_hold", tim_hold, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_idx", sym_idx, 0);
    check_eq("rst_presc", tim_prescaler, 0);
    sys_rst = 1'b0;

    // basic two-symbol sequence
    write_sym(0, 1'b1, 3);
    write_sym(1, 1'b0, 2);
    d0 = done_count;
    start_seq(4'd5, 1, 0);
    wait_idle(300);
    check_eq("basic_done_pulses", done_count - d0, 1);

    // single symbol repeated three times
    write_sym(0, 1'b1, 1);
    d0 = done_count;
    start_seq(4'd3, 0, 2);
    wait_idle(300);
    check_eq("loop_done_pulses", done_count - d0, 1);

    // stop in the middle of symbol 1, then replay
    write_sym(0, 1'b0, 3);
    write_sym(1, 1'b1, 5);
    start_seq(4'd2, 1, 0);
    c = 0;
    while (!(sym_idx == AW'(1) && !tim_hold) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_eq("reach_sym1", (c < 200), 1);
    repeat (3) @(negedge clk);
    d0 = done_count;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("stop_pulse", pulse_out, 0);
    check_eq("stop_hold", tim_hold, 1);
    check_eq("stop_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("stop_no_done", done_count - d0, 0);
    sb.delete();
    start_seq(4'd2, 1, 0);
    wait_idle(300);

    // start while busy, config changes mid-run, memory rewrite of a later symbol
    write_sym(0, 1'b1, 6);
    write_sym(1, 1'b0, 2);
    tb_lvl[1] = 1'b1;
    tb_dur[1] = 3;
    d0 = done_count;
    start_seq(4'd7, 1, 1);
    write_hw(1, 1'b1, 3);
    @(negedge clk);
    start         = 1'b1;
    cfg_loops     = 8'd5;
    cfg_last_idx  = '0;
    cfg_prescaler = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check_eq("presc_latched", tim_prescaler, 7);
    wait_idle(500);
    check_eq("ignored_done_pulses", done_count - d0, 1);

    // start and stop together in IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_eq("startstop_busy", busy, 0);
    check_eq("startstop_hold", tim_hold, 1);

    // zero duration = 2^DB ticks, with timer edges during IDLE/LOAD discarded
    write_sym(0, 1'b1, 0);
    idle_glitch = 1'b1;
    start_seq(4'd1, 0, 0);
    idle_glitch = 1'b0;
    wait_idle(500);

    // asynchronous reset between edges in the middle of RUN
    write_sym(0, 1'b1, 8);
    start_seq(4'd6, 0, 0);
    repeat (6) @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    check_eq("arst_pulse", pulse_out, 0);
    check_eq("arst_hold", tim_hold, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_idx", sym_idx, 0);
    check_eq("arst_presc", tim_prescaler, 0);
    @(negedge clk);
    sb.delete();
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_arst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
